// File: rtl/serial_bus_pkg.sv
// Shared opcodes and receive-side state encoding for the serial system bus.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_bus_pkg;

    localparam logic [2:0] READ_OP  = 3'b001;
    localparam logic [2:0] WRITE_OP = 3'b010;

    // Also used by the master tx port, so keep the encoding stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/master_rx_port_if.sv
// Bundle of the slave-facing serial handshake and core-facing control/read signals.
// Latency: n/a (wiring only).
// Backpressure: m_ready towards the slave, rd_ready from the core.
//  master modport: the receive port itself (drives m_ready, rd_*, status).
//  slave  modport: the surroundings (slave serial lines and master core).
interface master_rx_port_if #(
    parameter int WORD_SIZE = 8,
    parameter int LANES     = 1,
    parameter int BURST_W   = 15
);
    logic [LANES-1:0]     rx_data;
    logic                 s_valid;
    logic                 m_ready;
    logic [2:0]           instruction;
    logic [BURST_W-1:0]   burst_len;
    logic                 abort;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic                 busy;
    logic                 rx_done;
    logic                 rx_err;
    logic [BURST_W-1:0]   word_cnt;

    modport master (
        input  rx_data, s_valid, instruction, burst_len, abort, rd_ready,
        output m_ready, rd_data, rd_valid, busy, rx_done, rx_err, word_cnt
    );

    modport slave (
        output rx_data, s_valid, instruction, burst_len, abort, rd_ready,
        input  m_ready, rd_data, rd_valid, busy, rx_done, rx_err, word_cnt
    );
endinterface

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO holding received words for the core.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
//  i_push/i_push_dat: write side; i_pop: consume head; o_head_dat/o_vld: head word
//  (zero when empty); o_count: current fill level.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_vld,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    // When full, the slot being freed by a same-cycle pop can take the new word.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_vld      = (r_count != '0);
    // Stale memory is masked so the head reads zero after reset or when drained.
    assign o_head_dat = o_vld ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;

endmodule

// File: rtl/master_rx_port.sv
// Master-side serial receive port: READ burst control, multi-lane deserialiser, output FIFO.
// Latency: word pushed WORD_SIZE/LANES cycles after its handshake, at the head one cycle later.
// Backpressure: m_ready is only granted while the output FIFO has a free slot.
//  clk/rst: clock and async active-high reset; bus (master modport): slave serial lines
//  rx_data/s_valid/m_ready, core opcode/burst_len/abort, FIFO read side rd_*, status busy/
//  rx_done/rx_err/word_cnt.
module master_rx_port #(
    parameter int WORD_SIZE  = 8,
    parameter int LANES      = 1,
    parameter int BURST_W    = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    master_rx_port_if.master  bus
);
    import serial_bus_pkg::*;

    localparam int BEATS    = WORD_SIZE / LANES;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit TMO_EN   = (TIMEOUT > 0);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;

    if ((WORD_SIZE % LANES) != 0) begin : g_bad_lanes
        $error("master_rx_port: WORD_SIZE must be a multiple of LANES");
    end

    rx_state_t            r_state;
    logic                 r_m_ready;
    logic                 r_done;
    logic                 r_err;
    logic [BEAT_W-1:0]    r_beat;
    logic [TMO_W-1:0]     r_tmo;
    logic [BURST_W-1:0]   r_burst_len;
    logic [BURST_W-1:0]   r_word_cnt;

    logic [WORD_SIZE-1:0] w_word;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_vld;
    logic [CW-1:0]        w_fifo_cnt;
    logic [BURST_W-1:0]   w_cnt_inc;

    assign w_hs      = (r_state == WAIT) && bus.s_valid && r_m_ready;
    assign w_last    = (r_state == SHIFT) && (r_beat == BEAT_W'(BEATS - 1));
    // An abort on the final beat still wins: the word is never written.
    assign w_push    = w_last && !bus.abort;
    assign w_pop     = w_fifo_vld && bus.rd_ready;
    assign w_cnt_inc = r_word_cnt + BURST_W'(1);

    // Lane groups arrive LSB group first; each beat enters at the top and the
    // older groups slide down, so the first group ends up in the low bits.
    if (BEATS > 1) begin : g_shift
        logic [WORD_SIZE-LANES-1:0] r_shift;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_shift <= '0;
            end else if (r_state == SHIFT) begin
                r_shift <= w_word[WORD_SIZE-1:LANES];
            end
        end

        assign w_word = {bus.rx_data, r_shift};
    end else begin : g_no_shift
        assign w_word = bus.rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_m_ready   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_beat      <= '0;
            r_tmo       <= '0;
            r_burst_len <= '0;
            r_word_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.instruction == READ_OP) begin
                        r_burst_len <= bus.burst_len;
                        r_word_cnt  <= '0;
                        if (bus.burst_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= WAIT;
                            r_m_ready <= 1'b0;
                            r_tmo     <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.abort) begin
                        r_state   <= IDLE;
                        r_m_ready <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else if (w_hs) begin
                        r_state   <= SHIFT;
                        r_m_ready <= 1'b0;
                        r_beat    <= '0;
                        r_tmo     <= '0;
                    end else if (TMO_EN && (r_tmo == TMO_W'(TMO_LAST))) begin
                        r_state   <= IDLE;
                        r_m_ready <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        // Pops only lower the count and pushes never happen in
                        // WAIT, so a grant from last cycle's count is always safe.
                        r_tmo     <= r_tmo + TMO_W'(1);
                        r_m_ready <= (w_fifo_cnt < CW'(FIFO_DEPTH));
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        r_state   <= IDLE;
                        r_m_ready <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else if (w_last) begin
                        r_word_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_burst_len) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= WAIT;
                            r_m_ready <= 1'b0;
                            r_tmo     <= '0;
                        end
                    end else begin
                        r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_m_ready <= 1'b0;
                end
            endcase
        end
    end

    rx_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat (w_word),
        .i_pop      (w_pop),
        .o_head_dat (bus.rd_data),
        .o_vld      (w_fifo_vld),
        .o_count    (w_fifo_cnt)
    );

    assign bus.m_ready  = r_m_ready;
    assign bus.rd_valid = w_fifo_vld;
    assign bus.busy     = (r_state != IDLE);
    assign bus.rx_done  = r_done;
    assign bus.rx_err   = r_err;
    assign bus.word_cnt = r_word_cnt;

endmodule

// File: tb/tb_master_rx_port.sv
// Bench for master_rx_port: random slave words and core pops against a word-queue model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: core rd_ready is driven always-on, random, held-then-released or held off.
module tb_master_rx_port;
    import serial_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    master_rx_port_if #(.WORD_SIZE(8), .LANES(1), .BURST_W(15)) bus  ();
    master_rx_port_if #(.WORD_SIZE(8), .LANES(4), .BURST_W(15)) bus4 ();

    master_rx_port #(.WORD_SIZE(8), .LANES(1), .BURST_W(15), .FIFO_DEPTH(4), .TIMEOUT(10))
        u_dut  (.clk(clk), .rst(rst), .bus(bus));
    master_rx_port #(.WORD_SIZE(8), .LANES(4), .BURST_W(15), .FIFO_DEPTH(4), .TIMEOUT(10))
        u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int total = 0;
    int bad   = 0;
    logic [7:0] slv_q [$];   // words the slave still has to send
    logic [7:0] exp_q [$];   // words that must be in the FIFO, oldest first

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) slv_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_ready"},  bus.m_ready,  0);
        check({tag, "_rx_done"},  bus.rx_done,  0);
        check({tag, "_rx_err"},   bus.rx_err,   0);
        check({tag, "_busy"},     bus.busy,     0);
        check({tag, "_word_cnt"}, bus.word_cnt, 0);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_rd_data"},  bus.rd_data,  0);
    endtask

    // One READ burst of n words. ev_word/ev_beat pick a beat at which an abort
    // (or, with ev_rst, a reset) is applied; ev_word<0 means none.
    // mode: 0 rd_ready=1, 1 random rd_ready + READ noise, 2 hold until stalled, 3 rd_ready=0.
    task automatic run_burst(input int n, input int ev_word, input int ev_beat,
                             input bit ev_rst, input int mode);
        int sent = 0;
        int beat = -1;
        int gap  = 0;
        int cyc  = 0;
        int stall_cnt = 0;
        bit exp_done = 0;
        bit exp_err  = 0;
        bit stall_seen = 0;
        bit rdy_rel = 0;
        logic [7:0] cur = '0;
        logic [7:0] dummy;
        bus.instruction = READ_OP;
        bus.burst_len   = 15'(n);
        @(posedge clk); #1;
        bus.instruction = 3'b000;
        forever begin
            check("rx_done", bus.rx_done, exp_done);
            check("rx_err",  bus.rx_err,  exp_err);
            check("rd_valid", bus.rd_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("rd_data", bus.rd_data, exp_q[0]);
            if (bus.m_ready) check("m_ready_room", exp_q.size() < 4, 1);
            if (exp_done) begin
                check("busy_end",    bus.busy,     0);
                check("m_ready_end", bus.m_ready,  0);
                check("word_cnt",    bus.word_cnt, sent);
                if (mode == 2) check("stall_seen", stall_seen, 1);
                break;
            end
            if (cyc > 400) begin
                check("burst_budget", cyc, 400);
                break;
            end
            bus.abort = 1'b0;
            bus.s_valid = 1'b0;
            bus.rx_data = '0;
            bus.instruction = 3'b000;
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
                bus.instruction = READ_OP;
                bus.burst_len   = 15'd1;
            end
            if (beat >= 0) begin
                bus.rx_data = cur[beat];
                if (sent == ev_word && beat == ev_beat) begin
                    if (ev_rst) begin
                        rst = 1'b1;
                        #1;
                        check_reset_vals("mid_rst");
                        rst = 1'b0;
                        exp_q.delete();
                        slv_q.delete();
                        bus.rx_data = '0;
                        bus.rd_ready = 1'b0;
                        return;
                    end
                    bus.abort = 1'b1;
                    exp_done = 1'b1;
                    exp_err  = 1'b1;
                    beat = -1;
                    slv_q.delete();
                end else if (beat == 7) begin
                    exp_q.push_back(cur);
                    sent++;
                    beat = -1;
                    if (sent == n) exp_done = 1'b1;
                end else begin
                    beat++;
                end
            end else if (sent < n) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    bus.s_valid = 1'b1;
                    if (bus.m_ready) begin
                        cur  = slv_q.pop_front();
                        beat = 0;
                        gap  = $urandom_range(0, 2);
                    end
                end
            end
            case (mode)
                0: bus.rd_ready = 1'b1;
                1: bus.rd_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (exp_q.size() >= 4 && !bus.m_ready) begin
                        stall_seen = 1'b1;
                        stall_cnt++;
                    end
                    if (stall_cnt >= 3) rdy_rel = 1'b1;
                    bus.rd_ready = rdy_rel;
                end
                default: bus.rd_ready = 1'b0;
            endcase
            if (bus.rd_ready && bus.rd_valid) dummy = exp_q.pop_front();
            @(posedge clk); #1;
            cyc++;
        end
        bus.abort = 1'b0;
        bus.s_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.instruction = 3'b000;
        bus.rx_data = '0;
    endtask

    task automatic drain();
        int k = 0;
        logic [7:0] d;
        @(posedge clk); #1;
        bus.rd_ready = 1'b1;
        check("done_low", bus.rx_done, 0);
        while (k < 20) begin
            check("dr_valid", bus.rd_valid, exp_q.size() != 0);
            if (exp_q.size() == 0) break;
            check("dr_data", bus.rd_data, exp_q[0]);
            d = exp_q.pop_front();
            @(posedge clk); #1;
            k++;
        end
        bus.rd_ready = 1'b0;
    endtask

    // Single-word burst on the 4-lane port: low nibble first, high nibble second.
    task automatic lane4_word(input logic [7:0] w);
        int k = 0;
        bus4.instruction = READ_OP;
        bus4.burst_len   = 15'd1;
        @(posedge clk); #1;
        bus4.instruction = 3'b000;
        bus4.s_valid = 1'b1;
        while (!bus4.m_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("l4_grant", bus4.m_ready, 1);
        @(posedge clk); #1;
        bus4.s_valid = 1'b0;
        bus4.rx_data = w[3:0];
        check("l4_early0", bus4.rd_valid, 0);
        @(posedge clk); #1;
        bus4.rx_data = w[7:4];
        check("l4_early1", bus4.rd_valid, 0);
        @(posedge clk); #1;
        bus4.rx_data = '0;
        check("l4_valid", bus4.rd_valid, 1);
        check("l4_data",  bus4.rd_data,  w);
        check("l4_done",  bus4.rx_done,  1);
        check("l4_cnt",   bus4.word_cnt, 1);
        @(posedge clk); #1;
        check("l4_empty", bus4.rd_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_data = '0;  bus.s_valid = 1'b0;  bus.instruction = 3'b000;
        bus.burst_len = '0; bus.abort = 1'b0;   bus.rd_ready = 1'b0;
        bus4.rx_data = '0; bus4.s_valid = 1'b0; bus4.instruction = 3'b000;
        bus4.burst_len = '0; bus4.abort = 1'b0; bus4.rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        check("reset_l4_valid", bus4.rd_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed three-word burst.
        slv_q.push_back(8'hA5);
        slv_q.push_back(8'h3C);
        slv_q.push_back(8'hFF);
        run_burst(3, -1, 0, 1'b0, 0);
        drain();

        // Four-lane deserialisation.
        lane4_word(8'hB7);
        lane4_word(8'($urandom_range(0, 255)));
        lane4_word(8'($urandom_range(0, 255)));

        // FIFO fills, grant drops, core releases, rest of the burst arrives.
        fill(6);
        run_burst(6, -1, 0, 1'b0, 2);
        drain();

        // Back-to-back random bursts with random pops and READ issued while busy.
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 7);
            fill(n);
            run_burst(n, -1, 0, 1'b0, 1);
        end
        drain();

        // Zero-length burst.
        bus.instruction = READ_OP;
        bus.burst_len   = 15'd0;
        @(posedge clk); #1;
        bus.instruction = 3'b000;
        check("z_done",     bus.rx_done,  1);
        check("z_err",      bus.rx_err,   0);
        check("z_busy",     bus.busy,     0);
        check("z_m_ready",  bus.m_ready,  0);
        check("z_word_cnt", bus.word_cnt, 0);
        @(posedge clk); #1;
        check("z_done_low", bus.rx_done,  0);
        check("z_m_ready2", bus.m_ready,  0);

        // Timeout with a silent slave.
        bus.instruction = READ_OP;
        bus.burst_len   = 15'd3;
        @(posedge clk); #1;
        bus.instruction = 3'b000;
        for (int i = 0; i <= 10; i++) begin
            check("to_done", bus.rx_done, i == 10);
            if (i == 5) check("to_m_ready_wait", bus.m_ready, 1);
            if (i < 10) begin
                @(posedge clk); #1;
            end
        end
        check("to_err",     bus.rx_err,  1);
        check("to_busy",    bus.busy,    0);
        check("to_m_ready", bus.m_ready, 0);

        // Abort at beat 3 of the second word of a 4-word burst.
        fill(4);
        run_burst(4, 1, 3, 1'b0, 3);
        drain();

        // Reset in the middle of the second word, then a clean burst.
        fill(3);
        run_burst(3, 1, 4, 1'b1, 3);
        fill(2);
        run_burst(2, -1, 0, 1'b0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
